// File: rtl/shifter_pipelined_if.sv
// Handshake bundle for shifter_pipelined: operand side (in_*) and result side (out_*).
// The slave modport is the shifter's view; the master modport is the producer/consumer view.
interface shifter_pipelined_if #(
   parameter int unsigned N = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in;
   logic [N-1:0]  shamt;
   logic [1:0]    mode;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out;

   modport master (
      output in_valid, in, shamt, mode, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, in, shamt, mode, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/shifter_pipelined.sv
// Log-depth barrel shifter (SLL/SRL/SRA/ROR) with one register stage per shamt bit.
// The whole pipe advances together whenever the final stage is empty or being consumed.
module shifter_pipelined #(
   parameter int unsigned N = 32
) (
   input  logic             clk,
   input  logic             rst,
   shifter_pipelined_if.slave bus
);
   localparam int unsigned S = $clog2(N);

   typedef enum logic [1:0] {
      MODE_SLL = 2'b00,
      MODE_SRL = 2'b01,
      MODE_SRA = 2'b10,
      MODE_ROR = 2'b11
   } mode_e;

   logic adv;

   function automatic logic [N-1:0] stage_op(input logic [N-1:0] x, input mode_e m,
                                             input logic sgn, input int unsigned a);
      logic [N-1:0] ones;
      logic [N-1:0] r;
      ones = '1;
      case (m)
         MODE_SLL: r = x << a;
         MODE_SRL: r = x >> a;
         MODE_SRA: r = (x >> a) | (sgn ? ~(ones >> a) : '0);
         default:  r = (x >> a) | (x << (N - a));
      endcase
      return r;
   endfunction

   assign adv = !g_stage[S-1].valid_q || bus.out_ready;

   for (genvar k = 0; k < S; k++) begin : g_stage
      logic          p_valid, p_sign, p_ovf;
      logic [N-1:0]  p_data;
      logic [S-1:0]  p_amt;
      mode_e         p_mode;

      logic          valid_q, valid_d;
      logic          sign_q, sign_d;
      logic          ovf_q, ovf_d;
      logic [N-1:0]  data_q, data_d;
      logic [S-1:0]  amt_q, amt_d;
      mode_e         mode_q, mode_d;

      if (k == 0) begin : g_src
         assign p_valid = bus.in_valid;
         assign p_data  = bus.in;
         assign p_amt   = bus.shamt[S-1:0];
         assign p_mode  = mode_e'(bus.mode);
         assign p_sign  = bus.in[N-1];
         assign p_ovf   = |bus.shamt[N-1:S];
      end else begin : g_src
         assign p_valid = g_stage[k-1].valid_q;
         assign p_data  = g_stage[k-1].data_q;
         assign p_amt   = g_stage[k-1].amt_q;
         assign p_mode  = g_stage[k-1].mode_q;
         assign p_sign  = g_stage[k-1].sign_q;
         assign p_ovf   = g_stage[k-1].ovf_q;
      end

      always_comb begin
         valid_d = p_valid;
         amt_d   = p_amt;
         mode_d  = p_mode;
         sign_d  = p_sign;
         ovf_d   = p_ovf;
         data_d  = p_amt[k] ? stage_op(p_data, p_mode, p_sign, 2 ** k) : p_data;
         // Out-of-range shifts are resolved in the last stage so out stays a pure register.
         if ((k == S - 1) && p_ovf && (p_mode != MODE_ROR)) begin
            data_d = (p_mode == MODE_SRA) ? {N{p_sign}} : '0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= MODE_SLL;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
         end else if (adv) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
         end
      end
   end

   logic unused_tail;
   assign unused_tail = ^{g_stage[S-1].amt_q, g_stage[S-1].mode_q,
                          g_stage[S-1].sign_q, g_stage[S-1].ovf_q};

   assign bus.in_ready  = adv;
   assign bus.out_valid = g_stage[S-1].valid_q;
   assign bus.out       = g_stage[S-1].data_q;
endmodule

// File: doc/shifter_pipelined.md
SHIFTER_PIPELINED -- requirements
Module: shifter_pipelined

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits; power of two, >= 4.
REQ-002 SHALL have derived constant S = log2(N), default 5, number of pipeline stages.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand presented.
REQ-006 in_ready  output  1  block accepts operand this cycle.
REQ-007 in  input  N  value to shift.
REQ-008 shamt  input  N  shift amount, full N bits.
REQ-009 mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-010 out_valid  output  1  result presented.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out  output  N  shifted result.

Function
REQ-013 SHALL accept an operand on a cycle where in_valid && in_ready.
REQ-014 SHALL advance the whole pipeline on a cycle where adv = !out_valid || out_ready; otherwise all stage registers hold.
REQ-015 SHALL drive in_ready = adv, combinationally; no combinational path from in_valid to in_ready.
REQ-016 SHALL implement S register stages; stage k (0..S-1) applies a shift/rotate of 2^k positions when shamt bit k is set, else passes through.
REQ-017 SHALL carry valid, mode, sign (in[N-1] at accept) and an overflow flag with data through every stage.
REQ-018 SHALL compute overflow at accept as OR of shamt[N-1:S].
REQ-019 SLL SHALL fill with 0; SRL SHALL fill with 0; SRA SHALL fill with the captured sign; ROR SHALL wrap shifted-out LSBs into MSBs.
REQ-020 When overflow is set: SLL/SRL SHALL give all-zeros, SRA SHALL give N copies of sign, ROR SHALL ignore overflow (rotate by shamt mod N).
REQ-021 Latency SHALL be exactly S cycles from accept to out_valid when never stalled; throughput one result per cycle.
REQ-022 shamt = 0 SHALL return in unchanged for all modes.
REQ-023 out and out_valid SHALL come directly from final-stage registers and SHALL stay stable while out_valid && !out_ready.
REQ-024 Bubbles (cycles with no accept) SHALL propagate as invalid stages and are not compressed.
REQ-025 Results SHALL emerge in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-026 Accept and emit in the same cycle with a full pipeline SHALL be supported (adv high via out_ready).

Reset
REQ-027 While rst is high at a clock edge, all stage valid bits SHALL clear to 0 and all stage data/mode/sign/overflow registers SHALL clear to 0.
REQ-028 After reset: out_valid = 0, out = 0, in_ready = 1.
REQ-029 Reset mid-operation SHALL discard all in-flight operands; no result from before reset ever appears.
REQ-030 An operand presented in the same cycle as rst high SHALL NOT be accepted.

Verification (N=32, S=5)
REQ-031 SRL in=0x80000000, shamt=31 -> out=0x00000001, out_valid exactly 5 cycles after accept; SLL in=0x00000001, shamt=4 -> 0x00000010.
REQ-032 SRA in=0x80000000, shamt=4 -> 0xF8000000; SRA in=0x80000000, shamt=0x100 -> 0xFFFFFFFF; SRL same operands -> 0x00000000; SLL in=0xFFFFFFFF, shamt=32 -> 0x00000000.
REQ-033 ROR in=0x00000001, shamt=1 -> 0x80000000; shamt=33 -> 0x80000000; shamt=0 in=0xDEADBEEF, any mode -> 0xDEADBEEF.
REQ-034 Back-to-back 8 operands, out_ready low 3 cycles after pipe fills -> in_ready low those 3 cycles, out held stable, all 8 results delivered in order, none lost.
REQ-035 Reset asserted 2 cycles after accepting 3 operands -> out_valid stays 0 for the following 6 cycles with no new input; next accepted operand produces a correct result 5 cycles later.
